audio_pkt_mover: RTL and testbench

- Upstream feeder for the audio output block: copies one received USB isochronous audio packet (packed stereo 16-bit samples, one 32-bit word per frame) from the endpoint buffer RAM into the audio sample FIFO.
- Acts as a Wishbone master on the audio block's register space.
- Uses flow control from the FIFO level read back over the CSR, so the audio FIFO never drops a word.
- Commanded by the USB soft-core once per packet.

---
 rtl/audio_pkt_mover_if.sv | 28 ++
 rtl/audio_pkt_mover.sv | 238 +++++++++++++++++++++++
 tb/tb_audio_pkt_mover.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkt_mover_if.sv
// Wishbone classic bus between the packet mover (master) and the audio
// block's register space (slave).
interface audio_pkt_mover_if;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;

    modport master (
        output wb_addr,
        output wb_wdata,
        output wb_we,
        output wb_cyc,
        input  wb_rdata,
        input  wb_ack
    );

    modport slave (
        input  wb_addr,
        input  wb_wdata,
        input  wb_we,
        input  wb_cyc,
        output wb_rdata,
        output wb_ack
    );
endinterface

// File: rtl/audio_pkt_mover.sv
// audio_pkt_mover: copies one USB isochronous audio packet from the endpoint
// buffer RAM into the audio sample FIFO through the audio block's Wishbone
// registers, pacing the writes with the FIFO level read back from addr 0.
//
// Command handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high; cmd_addr/cmd_len are sampled on that edge only.
// cmd_ready is high exactly while the mover is idle, so cmd_valid during a
// packet is simply not taken.
module audio_pkt_mover #(
    parameter int EP_AW      = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int SAFETY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [EP_AW-1:0] cmd_addr,
    input  logic [EP_AW:0]   cmd_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             done_aborted,
    output logic [EP_AW:0]   words_left,
    output logic [EP_AW-1:0] ep_rd_addr,
    input  logic [31:0]      ep_rd_data,
    audio_pkt_mover_if.master wb,
    output logic [2:0]       dbg_state
);

    // Credit register width; the level arithmetic uses two extra bits so the
    // signed result never wraps for any 10-bit level value.
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 2;
    localparam logic signed [SW-1:0] CREDIT_MAX = SW'(FIFO_DEPTH - SAFETY);

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POLL   = 3'd1,
        S_FETCH  = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [EP_AW-1:0]  ptr_q, ptr_d;
    logic [EP_AW:0]    words_left_q, words_left_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic              wb_cyc_q, wb_cyc_d;
    logic              wb_we_q, wb_we_d;
    logic [1:0]        wb_addr_q, wb_addr_d;
    logic [31:0]       wb_wdata_q, wb_wdata_d;
    logic              fetch_wait_q, fetch_wait_d;
    logic              abort_pend_q, abort_pend_d;
    logic              aborted_q, aborted_d;

    logic              ack;
    logic [9:0]        lvl;
    logic signed [SW-1:0] lvl_ext;
    logic signed [SW-1:0] credit_raw;
    logic [CW-1:0]     credit_new;
    logic              rdata_unused;

    // Free space in the audio FIFO from the polled level, clamped at zero.
    always_comb begin
        lvl        = wb.wb_rdata[13:4];
        lvl_ext    = SW'(lvl);
        credit_raw = CREDIT_MAX - lvl_ext;
        if (credit_raw[SW-1] || (credit_raw == '0)) begin
            credit_new = '0;
        end else begin
            credit_new = credit_raw[CW-1:0];
        end
    end

    assign rdata_unused = ^{wb.wb_rdata[31:14], wb.wb_rdata[3:0]};

    // The slave re-acks while cyc is held, so only an ack inside our own
    // open cycle is meaningful.
    assign ack = wb_cyc_q & wb.wb_ack;

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        words_left_d = words_left_q;
        credit_d     = credit_q;
        wb_cyc_d     = wb_cyc_q;
        wb_we_d      = wb_we_q;
        wb_addr_d    = wb_addr_q;
        wb_wdata_d   = wb_wdata_q;
        fetch_wait_d = fetch_wait_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;

        unique case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                fetch_wait_d = 1'b0;
                if (cmd_valid) begin
                    ptr_d        = cmd_addr;
                    words_left_d = cmd_len;
                    credit_d     = '0;
                    aborted_d    = 1'b0;
                    state_d      = (cmd_len == '0) ? S_FINISH : S_POLL;
                end
            end

            S_POLL: begin
                if (wb_cyc_q) begin
                    // Level read in flight: an abort has to wait for the ack.
                    if (abort) begin
                        abort_pend_d = 1'b1;
                    end
                    if (ack) begin
                        wb_cyc_d = 1'b0;
                        if (abort || abort_pend_q) begin
                            abort_pend_d = 1'b0;
                            aborted_d    = 1'b1;
                            state_d      = S_FINISH;
                        end else begin
                            credit_d = credit_new;
                            if (credit_new != '0) begin
                                state_d = S_FETCH;
                            end
                        end
                    end
                end else if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    // Bus has been idle for at least this cycle: open the read.
                    wb_cyc_d  = 1'b1;
                    wb_we_d   = 1'b0;
                    wb_addr_d = ADDR_LEVEL;
                end
            end

            S_FETCH: begin
                if (abort) begin
                    fetch_wait_d = 1'b0;
                    aborted_d    = 1'b1;
                    state_d      = S_FINISH;
                end else if (!fetch_wait_q) begin
                    // RAM is reading ptr_q this cycle; data is valid next one.
                    fetch_wait_d = 1'b1;
                end else begin
                    fetch_wait_d = 1'b0;
                    wb_wdata_d   = ep_rd_data;
                    wb_cyc_d     = 1'b1;
                    wb_we_d      = 1'b1;
                    wb_addr_d    = ADDR_DATA;
                    state_d      = S_WRITE;
                end
            end

            S_WRITE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (ack) begin
                    // The acked word is in the FIFO even if abort arrived.
                    wb_cyc_d     = 1'b0;
                    wb_we_d      = 1'b0;
                    words_left_d = words_left_q - (EP_AW+1)'(1);
                    credit_d     = credit_q - CW'(1);
                    ptr_d        = ptr_q + EP_AW'(1);
                    if (abort || abort_pend_q) begin
                        abort_pend_d = 1'b0;
                        aborted_d    = 1'b1;
                        state_d      = S_FINISH;
                    end else if (words_left_q == (EP_AW+1)'(1)) begin
                        state_d = S_FINISH;
                    end else if (credit_q == CW'(1)) begin
                        state_d = S_POLL;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_FINISH: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any open bus cycle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            words_left_q <= '0;
            credit_q     <= '0;
            wb_cyc_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_wdata_q   <= '0;
            fetch_wait_q <= 1'b0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            words_left_q <= words_left_d;
            credit_q     <= credit_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_we_q      <= wb_we_d;
            wb_addr_q    <= wb_addr_d;
            wb_wdata_q   <= wb_wdata_d;
            fetch_wait_q <= fetch_wait_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign done_aborted = (state_q == S_FINISH) && aborted_q;
    assign words_left   = words_left_q;
    assign ep_rd_addr   = ptr_q;
    assign dbg_state    = state_q;

    assign wb.wb_cyc   = wb_cyc_q;
    assign wb.wb_we    = wb_we_q;
    assign wb.wb_addr  = wb_addr_q;
    assign wb.wb_wdata = wb_wdata_q;

endmodule

// File: tb/tb_audio_pkt_mover.sv
// Directed bench for audio_pkt_mover: endpoint RAM model, Wishbone audio
// slave model with programmable level and ack delay, and a linear sequence
// of packet scenarios checked with immediate assertions.
module tb_audio_pkt_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        done_aborted;
    logic [8:0]  words_left;
    logic [7:0]  ep_rd_addr;
    logic [31:0] ep_rd_data;
    logic [2:0]  dbg_state;

    audio_pkt_mover_if bus ();

    audio_pkt_mover #(.EP_AW(8), .FIFO_DEPTH(512), .SAFETY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .done_aborted (done_aborted),
        .words_left   (words_left),
        .ep_rd_addr   (ep_rd_addr),
        .ep_rd_data   (ep_rd_data),
        .wb           (bus),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Endpoint RAM content is a fixed function of the word address.
    function automatic logic [31:0] ep_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {16'hA55A, b, ~b};
    endfunction

    logic [31:0] ep_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) ep_mem[i] = ep_word(i);
    end
    always @(posedge clk) ep_rd_data <= ep_mem[ep_rd_addr];

    // Audio slave model: level register on addr 0, FIFO data on addr 2.
    logic [9:0]  lvl;
    int          ack_wait;
    int          wcnt;
    int          poll_cnt, write_cnt, cyc_seen, writes_at_poll2;
    int          bad_addr = 0;
    int          proto_err = 0;
    logic [31:0] got_q [$];
    logic        prev_ack = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [34:0] prev_req = '0;

    assign bus.wb_rdata = {18'h0, lvl, 4'h0};

    always @(posedge clk) begin
        if (bus.wb_cyc) cyc_seen++;
        if (bus.wb_cyc && bus.wb_ack) begin
            if (bus.wb_we) begin
                if (bus.wb_addr == 2'd2) begin
                    write_cnt++;
                    got_q.push_back(bus.wb_wdata);
                end else begin
                    bad_addr++;
                end
            end else begin
                if (bus.wb_addr == 2'd0) begin
                    if (poll_cnt == 1) writes_at_poll2 = write_cnt;
                    poll_cnt++;
                end else begin
                    bad_addr++;
                end
            end
        end
        if (prev_ack && bus.wb_cyc) proto_err++;
        if (prev_cyc && bus.wb_cyc && (prev_req != {bus.wb_addr, bus.wb_we, bus.wb_wdata})) proto_err++;
        prev_ack = bus.wb_ack;
        prev_cyc = bus.wb_cyc;
        prev_req = {bus.wb_addr, bus.wb_we, bus.wb_wdata};
        if (bus.wb_cyc && !bus.wb_ack) begin
            if (wcnt + 1 >= ack_wait) begin
                bus.wb_ack <= 1'b1;
                wcnt = 0;
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            bus.wb_ack <= 1'b0;
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        poll_cnt        = 0;
        write_cnt       = 0;
        cyc_seen        = 0;
        writes_at_poll2 = -1;
        got_q.delete();
    endtask

    task automatic start_cmd(input logic [7:0] a, input logic [8:0] n);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_write_open(input string tag);
        int n = 0;
        while (!(dbg_state == 3'd3 && bus.wb_cyc) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.wb_cyc), 32'd1);
    endtask

    task automatic check_data(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, (i < got_q.size()) ? got_q[i] : 32'hx, ep_word((first + i) % 256));
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        abort      = 1'b0;
        lvl        = '0;
        ack_wait   = 1;
        wcnt       = 0;
        bus.wb_ack = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_aborted", 32'(done_aborted), 32'd0);
        check("rst_cyc", 32'(bus.wb_cyc), 32'd0);
        check("rst_we", 32'(bus.wb_we), 32'd0);
        check("rst_addr", 32'(bus.wb_addr), 32'd0);
        check("rst_wdata", bus.wb_wdata, 32'd0);
        check("rst_ep_addr", 32'(ep_rd_addr), 32'd0);
        check("rst_words_left", 32'(words_left), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty FIFO: one poll, 48 writes of EP[0x10..0x3F].
        clear_counts();
        lvl = 10'd0;
        start_cmd(8'h10, 9'd48);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(1000, "t1_done");
        check("t1_aborted", 32'(done_aborted), 32'd0);
        check("t1_words_left", 32'(words_left), 32'd0);
        check("t1_writes", 32'(write_cnt), 32'd48);
        check_data("t1_data", 16, 48);
        repeat (10) @(negedge clk);
        check("t1_polls", 32'(poll_cnt), 32'd1);
        check("t1_idle", 32'(busy), 32'd0);

        // lvl=505 gives credit 5; after the FIFO drains the rest follow.
        clear_counts();
        lvl = 10'd505;
        start_cmd(8'h40, 9'd10);
        begin
            int n = 0;
            while (write_cnt < 5 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("t2_first_burst", 32'(write_cnt), 32'd5);
        lvl = 10'd0;
        wait_done(500, "t2_done");
        check("t2_writes_before_poll2", 32'(writes_at_poll2), 32'd5);
        check("t2_polls", 32'(poll_cnt), 32'd2);
        check("t2_writes", 32'(write_cnt), 32'd10);
        check("t2_aborted", 32'(done_aborted), 32'd0);
        check_data("t2_data", 8'h40, 10);

        // lvl=510 clamps credit to 0: only polls, then abort.
        clear_counts();
        lvl = 10'd510;
        start_cmd(8'h00, 9'd7);
        repeat (40) @(negedge clk);
        check("t3_no_writes", 32'(write_cnt), 32'd0);
        check("t3_repeat_polls", 32'(poll_cnt >= 5), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h80;
        cmd_len   = 9'd3;
        check("t3_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(50, "t3_done");
        check("t3_aborted", 32'(done_aborted), 32'd1);
        check("t3_words_left", 32'(words_left), 32'd7);
        repeat (5) @(negedge clk);
        check("t3_ignored_cmd", 32'(busy), 32'd0);
        check("t3_ep_addr", 32'(ep_rd_addr), 32'd0);
        check("t3_writes_end", 32'(write_cnt), 32'd0);

        // Address wrap 0xFE, 0xFF, 0x00, 0x01.
        clear_counts();
        lvl = 10'd0;
        start_cmd(8'hFE, 9'd4);
        wait_done(200, "t4_done");
        check("t4_writes", 32'(write_cnt), 32'd4);
        check_data("t4_data", 8'hFE, 4);
        check("t4_ep_addr", 32'(ep_rd_addr), 32'h02);

        // Zero-length packet: done right after accept, no bus cycle.
        clear_counts();
        start_cmd(8'h33, 9'd0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_aborted", 32'(done_aborted), 32'd0);
        check("t5_words_left", 32'(words_left), 32'd0);
        @(negedge clk);
        check("t5_done_pulse", 32'(done), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("t5_no_cyc", 32'(cyc_seen), 32'd0);

        // Abort with a write open: that word still counts.
        clear_counts();
        ack_wait = 4;
        start_cmd(8'h20, 9'd6);
        wait_write_open("t6_write_open");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(100, "t6_done");
        check("t6_aborted", 32'(done_aborted), 32'd1);
        check("t6_writes", 32'(write_cnt), 32'd1);
        check("t6_words_left", 32'(words_left), 32'd5);
        check_data("t6_data", 8'h20, 1);

        // Asynchronous reset in the middle of a write.
        clear_counts();
        start_cmd(8'h50, 9'd4);
        wait_write_open("t7_write_open");
        #2 rst = 1'b1;
        #1;
        check("t7_rst_cyc", 32'(bus.wb_cyc), 32'd0);
        check("t7_rst_ready", 32'(cmd_ready), 32'd1);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_words_left", 32'(words_left), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("t7_no_write", 32'(write_cnt), 32'd0);

        // Recovery after reset.
        clear_counts();
        ack_wait = 1;
        start_cmd(8'h08, 9'd2);
        wait_done(100, "t8_done");
        check_data("t8_data", 8'h08, 2);

        check("bus_protocol", 32'(proto_err), 32'd0);
        check("bus_bad_addr", 32'(bad_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
